// File: rtl/uart_echo_pkg.sv
// uart_echo_pkg: shared mode and transmit-FSM encodings for the UART echo buffer
package uart_echo_pkg;
    typedef enum logic [1:0] {
        MODE_PASS  = 2'b00,
        MODE_UPPER = 2'b01,
        MODE_DROP  = 2'b10,
        MODE_INV   = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        START     = 2'b01,
        WAIT_DONE = 2'b10
    } state_e;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with one extra pointer bit to tell full from empty
module sync_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic [DATA_W-1:0]            din,
    input  logic                         pop,
    output logic [DATA_W-1:0]            dout,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW:0]       wptr_q, wptr_d, rptr_q, rptr_d;
    logic              do_push, do_pop;

    always_comb begin
        count   = wptr_q - rptr_q;
        empty   = wptr_q == rptr_q;
        full    = wptr_q == {~rptr_q[AW], rptr_q[AW-1:0]};
        do_push = push && !full;
        do_pop  = pop && !empty;
        wptr_d  = do_push ? wptr_q + 1'b1 : wptr_q;
        rptr_d  = do_pop ? rptr_q + 1'b1 : rptr_q;
        dout    = mem_q[rptr_q[AW-1:0]];
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q[AW-1:0]] <= din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end
endmodule

// File: rtl/uart_echo_buffer.sv
// uart_echo_buffer: transforms received UART words, queues them and replays them
// to the transmitter one at a time; also flags overflow and drives an activity LED.
module uart_echo_buffer
    import uart_echo_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 16,
    parameter int LED_HOLD = 3_500_000
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         rx_valid,
    input  logic [DATA_W-1:0]            rx_data,
    input  logic                         tx_busy,
    input  logic [1:0]                   mode,
    input  logic                         clr_ovf,
    output logic                         tx_start,
    output logic [DATA_W-1:0]            tx_data,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_count,
    output logic                         overflow,
    output logic                         led
);
    localparam int LW = $clog2(LED_HOLD + 1);

    state_e            state_q, state_d;
    logic              tx_start_q, tx_start_d;
    logic [DATA_W-1:0] tx_data_q, tx_data_d, xf_data, head;
    logic              overflow_q, overflow_d;
    logic [LW-1:0]     led_cnt_q, led_cnt_d;
    logic              push, pop, full, empty, is_lower;

    sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   (xf_data),
        .pop   (pop),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (fifo_count)
    );

    // Upper-casing only makes sense for 8-bit ASCII; other widths pass through.
    always_comb begin
        is_lower   = DATA_W == 8 && rx_data >= DATA_W'('h61) && rx_data <= DATA_W'('h7A);
        xf_data    = mode == MODE_INV ? ~rx_data :
                     (mode == MODE_UPPER && is_lower) ? rx_data - DATA_W'('h20) : rx_data;
        push       = rx_valid && mode != MODE_DROP;
        overflow_d = (push && full) ? 1'b1 : clr_ovf ? 1'b0 : overflow_q;
        led_cnt_d  = rx_valid ? LW'(LED_HOLD) : (led_cnt_q != '0) ? led_cnt_q - 1'b1 : led_cnt_q;
    end

    always_comb begin
        state_d = (state_q == IDLE && !empty)         ? START :
                  (state_q == START && tx_busy)       ? WAIT_DONE :
                  (state_q == WAIT_DONE && !tx_busy)  ? IDLE : state_q;
    end

    always_comb begin
        pop        = state_q == IDLE && !empty;
        tx_data_d  = pop ? head : tx_data_q;
        tx_start_d = state_d == START;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
            overflow_q <= 1'b0;
            led_cnt_q  <= '0;
        end else begin
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
            overflow_q <= overflow_d;
            led_cnt_q  <= led_cnt_d;
        end
    end

    assign tx_start = tx_start_q;
    assign tx_data  = tx_data_q;
    assign overflow = overflow_q;
    assign led      = led_cnt_q != '0;
endmodule

// File: tb/tb_uart_echo_buffer.sv
// tb_uart_echo_buffer: scenario tasks plus a queue-based reference model of the
// echo path, with a small UART responder that answers tx_start with a busy frame.
module tb_uart_echo_buffer;
    localparam int DATA_W   = 8;
    localparam int DEPTH    = 16;
    localparam int LED_HOLD = 10;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic [1:0] mode = 2'b00;
    logic       clr_ovf = 1'b0;
    logic       man_busy = 1'b0;
    logic       auto_busy = 1'b0;
    logic       auto_en = 1'b0;
    logic       tx_busy;
    logic       tx_start;
    logic [7:0] tx_data;
    logic [4:0] fifo_count;
    logic       overflow;
    logic       led;

    int         total = 0;
    int         bad = 0;
    int         frame = 3;
    logic [7:0] got[$];
    logic       prev_start = 1'b0;

    assign tx_busy = auto_en ? auto_busy : man_busy;
    always #5 clk = ~clk;

    uart_echo_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .LED_HOLD(LED_HOLD)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .tx_busy    (tx_busy),
        .mode       (mode),
        .clr_ovf    (clr_ovf),
        .tx_start   (tx_start),
        .tx_data    (tx_data),
        .fifo_count (fifo_count),
        .overflow   (overflow),
        .led        (led)
    );

    // Every rising edge of tx_start is one word handed to the UART.
    always @(negedge clk) begin
        if (tx_start && !prev_start) got.push_back(tx_data);
        prev_start <= tx_start;
    end

    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (auto_en && tx_start) begin
                auto_busy = 1'b1;
                repeat (frame) @(posedge clk);
                #2;
                auto_busy = 1'b0;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] model_xf(input logic [1:0] m, input logic [7:0] d);
        if (m == 2'b11) return ~d;
        if (m == 2'b01 && d >= 8'h61 && d <= 8'h7A) return d - 8'h20;
        return d;
    endfunction

    task automatic send(input logic [1:0] m, input logic [7:0] d);
        mode = m;
        rx_data = d;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic wait_got(input int k, input int budget);
        int n = 0;
        while (got.size() < k && n < budget) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        total++; if (tx_start !== 1'b0) begin bad++; $display("FAIL reset_tx_start got=%b want=0", tx_start); end
        total++; if (tx_data !== 8'h00) begin bad++; $display("FAIL reset_tx_data got=%h want=00", tx_data); end
        total++; if (fifo_count !== 5'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", fifo_count); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow got=%b want=0", overflow); end
        total++; if (led !== 1'b0) begin bad++; $display("FAIL reset_led got=%b want=0", led); end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        auto_en = 1'b0;
        man_busy = 1'b0;
        got.delete();
        mode = 2'b00;
        rx_data = 8'h41;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        total++; if (fifo_count !== 5'd1) begin bad++; $display("FAIL single_count_n1 got=%0d want=1", fifo_count); end
        total++; if (tx_start !== 1'b0) begin bad++; $display("FAIL single_start_n1 got=%b want=0", tx_start); end
        tick();
        total++; if (tx_start !== 1'b1) begin bad++; $display("FAIL single_start_n2 got=%b want=1", tx_start); end
        total++; if (tx_data !== 8'h41) begin bad++; $display("FAIL single_data got=%h want=41", tx_data); end
        total++; if (fifo_count !== 5'd0) begin bad++; $display("FAIL single_count_n2 got=%0d want=0", fifo_count); end
        repeat (3) tick();
        total++; if (tx_start !== 1'b1) begin bad++; $display("FAIL single_start_hold got=%b want=1", tx_start); end
        man_busy = 1'b1;
        tick();
        total++; if (tx_start !== 1'b0) begin bad++; $display("FAIL single_start_drop got=%b want=0", tx_start); end
        man_busy = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_modes();
        logic [1:0] ms[4];
        logic [7:0] ins[4];
        logic [7:0] want;
        ms  = '{2'b01, 2'b01, 2'b01, 2'b11};
        ins = '{8'h61, 8'h5A, 8'h7B, 8'h0F};
        auto_en = 1'b1;
        frame = 4;
        for (int i = 0; i < 4; i++) begin
            got.delete();
            want = model_xf(ms[i], ins[i]);
            send(ms[i], ins[i]);
            wait_got(1, 50);
            total++;
            if (got.size() != 1 || got[0] !== want) begin
                bad++;
                $display("FAIL mode_%0d_in_%h got=%h n=%0d want=%h", ms[i], ins[i], got.size() > 0 ? got[0] : 8'hxx, got.size(), want);
            end
            repeat (frame + 6) tick();
        end
        got.delete();
        send(2'b10, 8'h55);
        total++; if (fifo_count !== 5'd0) begin bad++; $display("FAIL drop_count got=%0d want=0", fifo_count); end
        total++; if (led !== 1'b1) begin bad++; $display("FAIL drop_led got=%b want=1", led); end
        repeat (10) tick();
        total++; if (got.size() != 0) begin bad++; $display("FAIL drop_no_tx got=%0d words want=0", got.size()); end
    endtask

    task automatic test_overflow();
        auto_en = 1'b0;
        man_busy = 1'b1;
        got.delete();
        mode = 2'b00;
        for (int i = 0; i < 18; i++) begin
            rx_data = 8'(i);
            rx_valid = 1'b1;
            tick();
        end
        rx_valid = 1'b0;
        total++; if (fifo_count !== 5'd16) begin bad++; $display("FAIL ovf_count got=%0d want=16", fifo_count); end
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b want=1", overflow); end
        total++; if (got.size() != 1 || got[0] !== 8'h00) begin bad++; $display("FAIL ovf_inflight n=%0d want=1 word 00", got.size()); end
        rx_data = 8'h99;
        rx_valid = 1'b1;
        clr_ovf = 1'b1;
        tick();
        rx_valid = 1'b0;
        clr_ovf = 1'b0;
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_set_wins got=%b want=1", overflow); end
        total++; if (fifo_count !== 5'd16) begin bad++; $display("FAIL ovf_count_after got=%0d want=16", fifo_count); end
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_clear got=%b want=0", overflow); end
        frame = 100;
        auto_en = 1'b1;
        wait_got(17, 4000);
        total++; if (got.size() != 17) begin bad++; $display("FAIL ovf_drain_n got=%0d want=17", got.size()); end
        for (int i = 0; i < 17 && i < got.size(); i++) begin
            total++; if (got[i] !== 8'(i)) begin bad++; $display("FAIL ovf_order[%0d] got=%h want=%h", i, got[i], 8'(i)); end
        end
        total++; if (fifo_count !== 5'd0) begin bad++; $display("FAIL ovf_drain_count got=%0d want=0", fifo_count); end
        repeat (110) tick();
        man_busy = 1'b0;
        frame = 3;
    endtask

    task automatic test_led();
        int n = 0;
        while (led && n < 50) begin
            tick();
            n++;
        end
        total++; if (led !== 1'b0) begin bad++; $display("FAIL led_idle got=%b want=0", led); end
        mode = 2'b10;
        rx_data = 8'h00;
        rx_valid = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            tick();
            rx_valid = (c == 5);
            total++; if (led !== (c <= 15)) begin bad++; $display("FAIL led_cycle_%0d got=%b want=%b", c, led, c <= 15); end
        end
        rx_valid = 1'b0;
    endtask

    task automatic test_random();
        logic [7:0] exp[$];
        logic [1:0] m;
        logic [7:0] d;
        auto_en = 1'b1;
        got.delete();
        for (int c = 0; c < 400; c++) begin
            frame = $urandom_range(1, 4);
            if ($urandom_range(0, 11) == 0) begin
                m = 2'($urandom_range(0, 3));
                d = 8'($urandom);
                mode = m;
                rx_data = d;
                rx_valid = 1'b1;
                if (m != 2'b10) exp.push_back(model_xf(m, d));
            end else begin
                rx_valid = 1'b0;
            end
            tick();
        end
        rx_valid = 1'b0;
        wait_got(exp.size(), 500);
        total++; if (got.size() != exp.size()) begin bad++; $display("FAIL rand_n got=%0d want=%0d", got.size(), exp.size()); end
        for (int i = 0; i < exp.size() && i < got.size(); i++) begin
            total++; if (got[i] !== exp[i]) begin bad++; $display("FAIL rand_word[%0d] got=%h want=%h", i, got[i], exp[i]); end
        end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL rand_overflow got=%b want=0", overflow); end
        repeat (10) tick();
        total++; if (fifo_count !== 5'd0) begin bad++; $display("FAIL rand_count got=%0d want=0", fifo_count); end
    endtask

    task automatic test_reset_mid();
        auto_en = 1'b0;
        man_busy = 1'b0;
        got.delete();
        mode = 2'b00;
        for (int i = 0; i < 4; i++) begin
            rx_data = 8'hA1 + 8'(i);
            rx_valid = 1'b1;
            tick();
        end
        rx_valid = 1'b0;
        total++; if (tx_start !== 1'b1) begin bad++; $display("FAIL rmid_start got=%b want=1", tx_start); end
        total++; if (fifo_count !== 5'd3) begin bad++; $display("FAIL rmid_count got=%0d want=3", fifo_count); end
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (tx_start !== 1'b0) begin bad++; $display("FAIL rmid_async_start got=%b want=0", tx_start); end
        total++; if (fifo_count !== 5'd0) begin bad++; $display("FAIL rmid_async_count got=%0d want=0", fifo_count); end
        total++; if (led !== 1'b0) begin bad++; $display("FAIL rmid_async_led got=%b want=0", led); end
        tick();
        tick();
        rst_n = 1'b1;
        got.delete();
        repeat (20) tick();
        total++; if (got.size() != 0) begin bad++; $display("FAIL rmid_quiet got=%0d words want=0", got.size()); end
        send(2'b00, 8'h5C);
        wait_got(1, 20);
        total++; if (got.size() != 1 || got[0] !== 8'h5C) begin bad++; $display("FAIL rmid_after n=%0d want=1 word 5c", got.size()); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_modes();
        test_overflow();
        test_led();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
